// File: rtl/reg_file_sb_if.sv
// Bus between decode/issue/writeback and the integer register file:
// read ports, writeback, destination reservation, flush and busy count.
interface reg_file_sb_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRD  = 2
);
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wb_en;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                flush;
  logic [AW:0]         busy_cnt;

  modport master (
    output rd_addr, wb_en, wb_addr, wb_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  rd_addr, wb_en, wb_addr, wb_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_busy, busy_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// Integer register file with write-to-read bypass, hard-wired x0 and a per-register
// busy scoreboard (reserve at decode, release at writeback, clear on flush).
module reg_file_sb #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRD  = 2
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_sb_if.slave bus
);
  logic [NREG-1:0][XLEN-1:0] regs_q;
  logic [NREG-1:0]           busy_q;
  logic [AW-1:0]             ra [NRD];
  logic [AW:0]               cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      // A flush does not suppress the data write.
      if (bus.wb_en && (bus.wb_addr != '0)) begin
        regs_q[bus.wb_addr] <= bus.wb_data;
      end
      busy_q[0] <= 1'b0;
      for (int unsigned i = 1; i < NREG; i++) begin
        if (bus.flush) begin
          busy_q[i] <= 1'b0;
        end else if (bus.rsv_en && (bus.rsv_addr == AW'(i))) begin
          busy_q[i] <= 1'b1;
        end else if (bus.wb_en && (bus.wb_addr == AW'(i))) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NRD; k++) begin
      ra[k] = bus.rd_addr[k*AW +: AW];
    end
  end

  // Outputs are forced to zero while reset is held so the bypass path cannot leak.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      if (rst && (ra[k] != '0)) begin
        if (bus.wb_en && (bus.wb_addr == ra[k])) begin
          bus.rd_data[k*XLEN +: XLEN] = bus.wb_data;
          bus.rd_busy[k]              = bus.rsv_en && (bus.rsv_addr == ra[k]);
        end else begin
          bus.rd_data[k*XLEN +: XLEN] = regs_q[ra[k]];
          bus.rd_busy[k]              = busy_q[ra[k]];
        end
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      cnt = cnt + (AW+1)'(busy_q[i]);
    end
  end

  assign bus.busy_cnt = cnt;
endmodule
